// File: rtl/uart_receiver_fifo_param.sv
// UART receiver: 3-sample majority voting, 5-8 data bits, parity/stop/break checks,
// feeding a first-word-fall-through RX FIFO that holds data plus per-character status.
//   state      | meaning
//   S_IDLE     | line idle, waiting for a low sample
//   S_START    | validating the start bit
//   S_DATA     | shifting in data bits LSB-first
//   S_PARITY   | checking the parity bit
//   S_STOP     | checking the stop bit and pushing the character
//   S_BRK_WAIT | break seen, waiting for the line to return high
module uart_receiver_fifo_param #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             pclk,
    input  logic             utrrst,
    input  logic             sample_tick,
    input  logic             uart_rxd,
    input  logic             loop_txd,
    input  logic             loop,
    input  logic [1:0]       wls,
    input  logic             pen,
    input  logic             eps,
    input  logic             sp,
    input  logic             rx_rd,
    output logic [7:0]       rx_data,
    output logic             rx_pe,
    output logic             rx_fe,
    output logic             rx_bi,
    output logic             rx_valid,
    output logic [CNT_W-1:0] rx_count,
    output logic             overrun,
    output logic             rx_active
);

    localparam int TC_W  = $clog2(OVERSAMPLE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [TC_W-1:0] TC_S0   = TC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TC_W-1:0] TC_S1   = TC_W'(OVERSAMPLE / 2);
    localparam logic [TC_W-1:0] TC_VOTE = TC_W'(OVERSAMPLE / 2 + 1);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
    } state_t;

    logic              rx_s1_q, rxq_q;
    state_t            state_q, state_d;
    logic [TC_W-1:0]   tc_q, tc_d;
    logic              smp0_q, smp0_d, smp1_q, smp1_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        data_q, data_d;
    logic              pe_q, pe_d;
    logic              par_bit_q, par_bit_d;
    logic              overrun_q, overrun_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [10:0]       mem_q [FIFO_DEPTH];

    logic        voted, vote_tick, end_tick, last_bit, exp_par, brk;
    logic        push, full, empty, rd_en, wr_en;
    logic [10:0] push_word, head;

    assign voted     = (smp0_q & smp1_q) | (smp0_q & rxq_q) | (smp1_q & rxq_q);
    assign vote_tick = sample_tick && (tc_q == TC_VOTE);
    assign end_tick  = sample_tick && (tc_q == TC_LAST);
    assign last_bit  = (bit_idx_q == ({1'b0, wls} + 3'd4));
    assign exp_par   = sp ? ~eps : (eps ? ^data_q : ~^data_q);
    // par_bit_q stays 0 when parity is disabled, so it only vetoes a break when pen=1
    assign brk       = (data_q == 8'd0) && !par_bit_q && !voted;
    assign push_word = {data_q, pe_q, ~voted, brk};

    always_comb begin
        state_d   = state_q;
        tc_d      = tc_q;
        smp0_d    = smp0_q;
        smp1_d    = smp1_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        pe_d      = pe_q;
        par_bit_d = par_bit_q;
        push      = 1'b0;
        if (sample_tick) begin
            tc_d = (tc_q == TC_LAST) ? '0 : tc_q + 1'b1;
            if (tc_q == TC_S0) smp0_d = rxq_q;
            if (tc_q == TC_S1) smp1_d = rxq_q;
        end
        case (state_q)
            S_IDLE: begin
                if (sample_tick && !rxq_q) begin
                    state_d   = S_START;
                    tc_d      = '0;
                    bit_idx_d = '0;
                    data_d    = '0;
                    pe_d      = 1'b0;
                    par_bit_d = 1'b0;
                end
            end
            S_START: begin
                if (vote_tick && voted) state_d = S_IDLE;
                else if (end_tick) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (vote_tick) data_d[bit_idx_q] = voted;
                if (end_tick) begin
                    if (last_bit) state_d = pen ? S_PARITY : S_STOP;
                    else          bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_PARITY: begin
                if (vote_tick) begin
                    pe_d      = (voted != exp_par);
                    par_bit_d = voted;
                end
                if (end_tick) state_d = S_STOP;
            end
            S_STOP: begin
                if (vote_tick) begin
                    push    = 1'b1;
                    state_d = brk ? S_BRK_WAIT : S_IDLE;
                end
            end
            S_BRK_WAIT: begin
                if (sample_tick && rxq_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        empty     = (count_q == '0);
        rd_en     = rx_rd && !empty;
        // a full FIFO still accepts a push when the same cycle frees a slot
        wr_en     = push && (!full || rd_en);
        overrun_d = push && full && !rd_en;
        count_d   = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        wr_ptr_d  = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d  = rd_ptr_q + PTR_W'(rd_en);
    end

    always_ff @(posedge pclk) begin
        if (utrrst) begin
            rx_s1_q   <= 1'b1;
            rxq_q     <= 1'b1;
            state_q   <= S_IDLE;
            tc_q      <= '0;
            smp0_q    <= 1'b1;
            smp1_q    <= 1'b1;
            bit_idx_q <= '0;
            data_q    <= '0;
            pe_q      <= 1'b0;
            par_bit_q <= 1'b0;
            overrun_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            rx_s1_q   <= loop ? loop_txd : uart_rxd;
            rxq_q     <= rx_s1_q;
            state_q   <= state_d;
            tc_q      <= tc_d;
            smp0_q    <= smp0_d;
            smp1_q    <= smp1_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            pe_q      <= pe_d;
            par_bit_q <= par_bit_d;
            overrun_q <= overrun_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (wr_en && !utrrst) mem_q[wr_ptr_q] <= push_word;
    end

    // Gating by occupancy keeps the head at 0 when empty, including after reset
    assign head      = mem_q[rd_ptr_q];
    assign rx_valid  = !empty;
    assign rx_data   = rx_valid ? head[10:3] : 8'd0;
    assign rx_pe     = rx_valid & head[2];
    assign rx_fe     = rx_valid & head[1];
    assign rx_bi     = rx_valid & head[0];
    assign rx_count  = count_q;
    assign overrun   = overrun_q;
    assign rx_active = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver_fifo_param.sv
// Directed bench for uart_receiver_fifo_param: serial frames in, scoreboard of expected
// {data, pe, fe, bi} drained by a monitor that pops the FIFO while auto-read is on.
module tb_uart_receiver_fifo_param;

    localparam int CNT_W = 5;

    logic             pclk = 1'b0;
    logic             utrrst = 1'b1;
    logic             sample_tick = 1'b0;
    logic             uart_rxd = 1'b1;
    logic             loop_txd = 1'b1;
    logic             loop = 1'b0;
    logic [1:0]       wls = 2'b11;
    logic             pen = 1'b0;
    logic             eps = 1'b0;
    logic             sp = 1'b0;
    logic             rx_rd = 1'b0;
    logic [7:0]       rx_data;
    logic             rx_pe, rx_fe, rx_bi, rx_valid, overrun, rx_active;
    logic [CNT_W-1:0] rx_count;

    int          errors = 0;
    int          checks = 0;
    int          ovr_cnt = 0;
    bit          auto_rd = 1'b0;
    logic [10:0] exp_q[$];

    uart_receiver_fifo_param #(.OVERSAMPLE(16), .FIFO_DEPTH(16)) dut (
        .pclk(pclk), .utrrst(utrrst), .sample_tick(sample_tick),
        .uart_rxd(uart_rxd), .loop_txd(loop_txd), .loop(loop),
        .wls(wls), .pen(pen), .eps(eps), .sp(sp), .rx_rd(rx_rd),
        .rx_data(rx_data), .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_bi(rx_bi),
        .rx_valid(rx_valid), .rx_count(rx_count), .overrun(overrun),
        .rx_active(rx_active)
    );

    always #5 pclk = ~pclk;

    // one-cycle tick every second pclk
    initial begin
        logic [1:0] div = 2'd0;
        forever begin
            @(negedge pclk);
            div = div + 2'd1;
            sample_tick = div[0];
        end
    end

    initial forever begin
        @(negedge pclk);
        if (overrun) ovr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: compare head against scoreboard, then pop it
    initial forever begin
        @(negedge pclk);
        if (auto_rd && rx_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_push", {21'd0, rx_data, rx_pe, rx_fe, rx_bi}, 32'h7ff);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                chk("head", {21'd0, rx_data, rx_pe, rx_fe, rx_bi}, {21'd0, e});
            end
            rx_rd = 1'b1;
            @(negedge pclk);
            rx_rd = 1'b0;
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge pclk); while (!sample_tick);
        end
        @(negedge pclk);
    endtask

    task automatic set_line(input logic v);
        if (loop) loop_txd = v;
        else      uart_rxd = v;
    endtask

    task automatic send_bit(input logic v);
        set_line(v);
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit use_par,
                              input logic par_bit, input logic stop_bit, input int glitch_bit);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) begin
            if (i == glitch_bit) begin
                set_line(d[i]);  wait_ticks(8);
                set_line(~d[i]); wait_ticks(1);
                set_line(d[i]);  wait_ticks(7);
            end else begin
                send_bit(d[i]);
            end
        end
        if (use_par) send_bit(par_bit);
        send_bit(stop_bit);
        set_line(1'b1);
        wait_ticks(4);
    endtask

    task automatic expect_char(input logic [7:0] d, input logic pe_e, input logic fe_e, input logic bi_e);
        exp_q.push_back({d, pe_e, fe_e, bi_e});
    endtask

    task automatic drain();
        int n = 0;
        auto_rd = 1'b1;
        while ((exp_q.size() != 0 || rx_valid) && n < 2000) begin
            @(negedge pclk);
            n++;
        end
        repeat (3) @(negedge pclk);
        auto_rd = 1'b0;
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d entries still expected, rx_valid=%0b", exp_q.size(), rx_valid);
            exp_q.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge pclk);
        utrrst = 1'b0;
        @(negedge pclk);
        chk("rst_valid",  {31'd0, rx_valid}, 32'd0);
        chk("rst_count",  {27'd0, rx_count}, 32'd0);
        chk("rst_data",   {24'd0, rx_data}, 32'd0);
        chk("rst_status", {29'd0, rx_pe, rx_fe, rx_bi}, 32'd0);
        chk("rst_ovr",    {31'd0, overrun}, 32'd0);
        chk("rst_active", {31'd0, rx_active}, 32'd0);
        wait_ticks(4);

        // 8N1 0xA5
        wls = 2'b11; pen = 1'b0;
        expect_char(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1);
        chk("t1_count", {27'd0, rx_count}, 32'd1);
        chk("t1_valid", {31'd0, rx_valid}, 32'd1);
        drain();
        chk("t1_valid_after_rd", {31'd0, rx_valid}, 32'd0);

        // 7E1 0x35 (four ones -> even parity bit 0)
        wls = 2'b10; pen = 1'b1; eps = 1'b1; sp = 1'b0;
        expect_char(8'h35, 1'b1, 1'b0, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, -1);
        expect_char(8'h35, 1'b0, 1'b0, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, -1);
        chk("t2_count", {27'd0, rx_count}, 32'd2);
        drain();

        // false start, then a one-tick glitch inside data bit 2
        wls = 2'b11; pen = 1'b0; eps = 1'b0;
        set_line(1'b0);
        wait_ticks(4);
        set_line(1'b1);
        wait_ticks(20);
        chk("t3_active", {31'd0, rx_active}, 32'd0);
        chk("t3_count",  {27'd0, rx_count}, 32'd0);
        expect_char(8'hC3, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 2);
        drain();

        // break: line low for three frame times
        expect_char(8'h00, 1'b0, 1'b1, 1'b1);
        set_line(1'b0);
        wait_ticks(480);
        chk("t4_count_in_break", {27'd0, rx_count}, 32'd1);
        chk("t4_active_in_break", {31'd0, rx_active}, 32'd1);
        set_line(1'b1);
        wait_ticks(16);
        chk("t4_active_after", {31'd0, rx_active}, 32'd0);
        expect_char(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, -1);
        chk("t4_count", {27'd0, rx_count}, 32'd2);
        drain();

        // overflow: 17 frames, no reads; the 17th is dropped
        ovr_cnt = 0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expect_char(8'(i), 1'b0, 1'b0, 1'b0);
            send_frame(8'(i), 8, 1'b0, 1'b0, 1'b1, -1);
        end
        chk("t5_count", {27'd0, rx_count}, 32'd16);
        chk("t5_overrun_pulses", ovr_cnt, 32'd1);
        chk("t5_head", {24'd0, rx_data}, 32'h00);
        drain();
        chk("t5_empty", {27'd0, rx_count}, 32'd0);

        // loopback 6O1 0x3C (four ones -> odd parity bit 1)
        loop = 1'b1; uart_rxd = 1'b0;
        wls = 2'b01; pen = 1'b1; eps = 1'b0; sp = 1'b0;
        expect_char(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 6, 1'b1, 1'b1, 1'b1, -1);
        drain();
        send_frame(8'h15, 6, 1'b1, 1'b0, 1'b1, -1);
        chk("t6_count_before_rst", {27'd0, rx_count}, 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("t6_active_mid", {31'd0, rx_active}, 32'd1);
        utrrst = 1'b1;
        set_line(1'b1);
        @(negedge pclk);
        utrrst = 1'b0;
        chk("t6_count_after_rst",  {27'd0, rx_count}, 32'd0);
        chk("t6_active_after_rst", {31'd0, rx_active}, 32'd0);
        chk("t6_valid_after_rst",  {31'd0, rx_valid}, 32'd0);
        wait_ticks(40);
        chk("t6_count_idle", {27'd0, rx_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
